// File: rtl/simon_packet_driver.sv
// rtl/simon_packet_driver.sv - one-packet-in-flight initiator for the SIMON control core.
// Optional result checker enabled by defining SIMON_DRV_CHECK_EN.
module simon_packet_driver #(
   parameter int N       = 16,
   parameter int M       = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic             clk,
   input  logic             nR,
   input  logic             pkt_valid,
   output logic             pkt_ready,
   input  logic [2*N-1:0]   pkt_data,
   input  logic [7:0]       pkt_info,
   input  logic [7:0]       pkt_count,
   input  logic             pkt_key_vld,
   input  logic [M*N-1:0]   pkt_key,
   output logic             newDATA,
   output logic             newKEY,
   output logic [7:0]       infoIN,
   output logic [7:0]       countIN,
   output logic [2*N-1:0]   inDATA,
   output logic [M*N-1:0]   KEY,
   input  logic             loadDATA,
   input  logic             loadKEY,
   input  logic             doneDATA,
   output logic             readDATA,
   input  logic [7:0]       infoOUT,
   input  logic [7:0]       countOUT,
   input  logic [2*N-1:0]   outDATA,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [2*N-1:0]   res_data,
   output logic [7:0]       res_info,
   output logic [7:0]       res_count,
   output logic             res_err,
   output logic             timeout
);

   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_EXEC,
      S_ACK,
      S_OUT
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_wd_cnt;
   logic [CW-1:0]   w_wd_inc;
   logic            w_wd_fire;
   logic            w_wd_to;
   logic            w_accept;
   logic            w_load_done;
   logic            w_wd_active;

   logic            r_pkt_ready;
   logic            r_new_data;
   logic            r_new_key;
   logic            r_read;
   logic            r_res_valid;
   logic            r_timeout;
   logic [2*N-1:0]  r_in_data;
   logic [7:0]      r_info_in;
   logic [7:0]      r_count_in;
   logic [M*N-1:0]  r_key;
   logic [2*N-1:0]  r_res_data;
   logic [7:0]      r_res_info;
   logic [7:0]      r_res_count;

   assign w_accept    = (r_state == S_IDLE) && pkt_valid && r_pkt_ready;
   // A request that has already dropped counts as acknowledged.
   assign w_load_done = (!r_new_data || loadDATA) && (!r_new_key || loadKEY);
   assign w_wd_active = (r_state == S_LOAD) || (r_state == S_EXEC);
   assign w_wd_inc    = r_wd_cnt + 1'b1;
   assign w_wd_fire   = w_wd_active && (w_wd_inc == WD_LIMIT);

   always_comb begin
      w_next  = r_state;
      w_wd_to = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next = S_LOAD;
         end
         S_LOAD: begin
            if (w_load_done) begin
               w_next = S_EXEC;
            end else if (w_wd_fire) begin
               w_next  = S_IDLE;
               w_wd_to = 1'b1;
            end
         end
         S_EXEC: begin
            if (doneDATA) begin
               w_next = S_ACK;
            end else if (w_wd_fire) begin
               w_next  = S_IDLE;
               w_wd_to = 1'b1;
            end
         end
         S_ACK: w_next = S_OUT;
         S_OUT: begin
            if (res_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nR) begin
      if (!nR) begin
         r_state     <= S_IDLE;
         r_wd_cnt    <= '0;
         r_pkt_ready <= 1'b0;
         r_new_data  <= 1'b0;
         r_new_key   <= 1'b0;
         r_read      <= 1'b0;
         r_res_valid <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_next;
         // Hold off one extra cycle after a timeout so newDATA stays low for two cycles.
         r_pkt_ready <= (w_next == S_IDLE) && !w_wd_to;
         r_read      <= (w_next == S_ACK);
         r_res_valid <= (w_next == S_OUT);
         r_timeout   <= w_wd_to;

         if ((w_next != r_state) && ((w_next == S_LOAD) || (w_next == S_EXEC))) begin
            r_wd_cnt <= '0;
         end else if (w_wd_active) begin
            r_wd_cnt <= w_wd_inc;
         end

         if (w_accept) begin
            r_new_data <= 1'b1;
         end else if ((r_state != S_LOAD) || loadDATA || w_wd_to) begin
            r_new_data <= 1'b0;
         end

         if (w_accept) begin
            r_new_key <= pkt_key_vld;
         end else if ((r_state != S_LOAD) || loadKEY || w_wd_to) begin
            r_new_key <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge nR) begin
      if (!nR) begin
         r_in_data  <= '0;
         r_info_in  <= '0;
         r_count_in <= '0;
         r_key      <= '0;
      end else if (w_accept) begin
         r_in_data  <= pkt_data;
         r_info_in  <= pkt_info;
         r_count_in <= pkt_count;
         if (pkt_key_vld) r_key <= pkt_key;
      end
   end

   always_ff @(posedge clk or negedge nR) begin
      if (!nR) begin
         r_res_data  <= '0;
         r_res_info  <= '0;
         r_res_count <= '0;
      end else if ((r_state == S_EXEC) && doneDATA) begin
         r_res_data  <= outDATA;
         r_res_info  <= infoOUT;
         r_res_count <= countOUT;
      end
   end

`ifdef SIMON_DRV_CHECK_EN
   logic r_res_err;
   logic w_chk_err;

   // The core is expected to echo the count and invert the direction flag.
   assign w_chk_err = (countOUT != r_count_in) || (infoOUT[4] != ~r_info_in[4]);

   always_ff @(posedge clk or negedge nR) begin
      if (!nR) begin
         r_res_err <= 1'b0;
      end else if ((r_state == S_EXEC) && doneDATA) begin
         r_res_err <= w_chk_err;
      end
   end

   assign res_err = r_res_err;
`else
   assign res_err = 1'b0;
`endif

   assign pkt_ready = r_pkt_ready;
   assign newDATA   = r_new_data;
   assign newKEY    = r_new_key;
   assign inDATA    = r_in_data;
   assign infoIN    = r_info_in;
   assign countIN   = r_count_in;
   assign KEY       = r_key;
   assign readDATA  = r_read;
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign res_info  = r_res_info;
   assign res_count = r_res_count;
   assign timeout   = r_timeout;

endmodule
